// File: rtl/axi_rd_pkg.sv
// Shared types, constants and helpers for the AXI read request generator.
package axi_rd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CALC  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } req_gen_state_e;

    // Bursts must never straddle this address boundary.
    localparam int unsigned BOUNDARY_4K = 32'd4096;

    // Smallest of three unsigned values; callers zero-extend into 32 bits.
    function automatic logic [31:0] min3(input logic [31:0] a,
                                         input logic [31:0] b,
                                         input logic [31:0] c);
        logic [31:0] m;
        if (a < b) begin
            m = a;
        end else begin
            m = b;
        end
        if (c < m) begin
            m = c;
        end else begin
            m = m;
        end
        return m;
    endfunction

endpackage

// File: rtl/axi_burst_sizer.sv
// Combinational burst length: the smallest of the bytes still to read, the
// burst cap, and the distance to the next 4 KB boundary.
module axi_burst_sizer
    import axi_rd_pkg::*;
#(
    parameter int LEN_WIDTH       = 20,
    parameter int MAX_BURST_BYTES = 1024
) (
    input  logic [11:0]          addr_ofs_i,   // cur_addr mod 4096
    input  logic [LEN_WIDTH-1:0] remaining_i,
    output logic [LEN_WIDTH-1:0] blen_o
);

    logic [12:0] to_4k_s;

    // 13 bits so a 4 KB-aligned address yields a full 4096.
    assign to_4k_s = 13'(BOUNDARY_4K) - {1'b0, addr_ofs_i};
    assign blen_o  = LEN_WIDTH'(min3(32'(remaining_i),
                                     32'(MAX_BURST_BYTES),
                                     32'(to_4k_s)));

endmodule

// File: rtl/axi_rd_req_gen.sv
// Splits a read command into bursts (capped, no 4 KB crossing), issues them one
// at a time to the AXI read master, counts returned beats and aborts on a
// stalled transfer.
module axi_rd_req_gen
    import axi_rd_pkg::*;
#(
    parameter int AXI_DATA_WIDTH  = 32,
    parameter int AXI_ADDR_WIDTH  = 16,
    parameter int LEN_WIDTH       = 20,
    parameter int MAX_BURST_BYTES = 1024,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [AXI_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]      cmd_len,
    output logic                      req,
    output logic [AXI_ADDR_WIDTH-1:0] addr,
    output logic [LEN_WIDTH-1:0]      burst_len,
    input  logic                      data_valid,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [15:0]               burst_cnt
);

    localparam int STRB   = AXI_DATA_WIDTH / 8;
    localparam int OFS_W  = $clog2(STRB);
    localparam int BEAT_W = 9;
    localparam int WD_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_MASK = AXI_ADDR_WIDTH'(STRB - 1);
    localparam logic [LEN_WIDTH-1:0]      LEN_MASK  = LEN_WIDTH'(STRB - 1);

    req_gen_state_e              state_q, state_d;
    logic [AXI_ADDR_WIDTH-1:0]   cur_addr_q, cur_addr_d;
    logic [LEN_WIDTH-1:0]        remaining_q, remaining_d;
    logic [AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [LEN_WIDTH-1:0]        burst_len_q, burst_len_d;
    logic [BEAT_W-1:0]           beats_left_q, beats_left_d;
    logic [WD_W-1:0]             wdog_q, wdog_d;
    logic [15:0]                 burst_cnt_q, burst_cnt_d;
    logic                        err_q, err_d;
    logic                        req_q, req_d;
    logic                        done_q, done_d;
    logic                        busy_q, busy_d;
    logic                        cmd_ready_q, cmd_ready_d;

    logic [LEN_WIDTH-1:0]        blen_s;
    logic [WD_W-1:0]             wdog_inc_s;
    logic                        misaligned_s;

    axi_burst_sizer #(
        .LEN_WIDTH       (LEN_WIDTH),
        .MAX_BURST_BYTES (MAX_BURST_BYTES)
    ) u_sizer (
        .addr_ofs_i  (cur_addr_q[11:0]),
        .remaining_i (remaining_q),
        .blen_o      (blen_s)
    );

    assign misaligned_s = ((cmd_addr & ADDR_MASK) != '0) || ((cmd_len & LEN_MASK) != '0);
    assign wdog_inc_s   = wdog_q + WD_W'(1);

    // Next-state, datapath updates and registered-output decode.
    always_comb begin
        state_d      = state_q;
        cur_addr_d   = cur_addr_q;
        remaining_d  = remaining_q;
        addr_d       = addr_q;
        burst_len_d  = burst_len_q;
        beats_left_d = beats_left_q;
        wdog_d       = wdog_q;
        burst_cnt_d  = burst_cnt_q;
        err_d        = err_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    cur_addr_d  = cmd_addr;
                    remaining_d = cmd_len;
                    err_d       = 1'b0;
                    burst_cnt_d = 16'd0;
                    if (misaligned_s) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else if (cmd_len == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_CALC;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                addr_d       = cur_addr_q;
                burst_len_d  = blen_s;
                beats_left_d = BEAT_W'(blen_s >> OFS_W);
                state_d      = ST_ISSUE;
            end
            ST_ISSUE: begin
                burst_cnt_d = burst_cnt_q + 16'd1;
                wdog_d      = '0;
                state_d     = ST_WAIT;
            end
            ST_WAIT: begin
                if (data_valid) begin
                    beats_left_d = beats_left_q - BEAT_W'(1);
                    wdog_d       = '0;
                    if (beats_left_q == BEAT_W'(1)) begin
                        cur_addr_d  = cur_addr_q + AXI_ADDR_WIDTH'(burst_len_q);
                        remaining_d = remaining_q - burst_len_q;
                        if (remaining_q != burst_len_q) begin
                            state_d = ST_CALC;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else if (wdog_inc_s == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    // Stalled master: abandon whatever is left of the command.
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    wdog_d = wdog_inc_s;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they appear registered.
        req_d       = (state_d == ST_ISSUE);
        done_d      = (state_d == ST_DONE);
        busy_d      = (state_d != ST_IDLE);
        cmd_ready_d = (state_d == ST_IDLE);
    end

    // State and datapath registers; reset returns to idle with no pending request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cur_addr_q   <= '0;
            remaining_q  <= '0;
            addr_q       <= '0;
            burst_len_q  <= '0;
            beats_left_q <= '0;
            wdog_q       <= '0;
            burst_cnt_q  <= 16'd0;
            err_q        <= 1'b0;
            req_q        <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            cmd_ready_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            cur_addr_q   <= cur_addr_d;
            remaining_q  <= remaining_d;
            addr_q       <= addr_d;
            burst_len_q  <= burst_len_d;
            beats_left_q <= beats_left_d;
            wdog_q       <= wdog_d;
            burst_cnt_q  <= burst_cnt_d;
            err_q        <= err_d;
            req_q        <= req_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
            cmd_ready_q  <= cmd_ready_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign req       = req_q;
    assign addr      = addr_q;
    assign burst_len = burst_len_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign burst_cnt = burst_cnt_q;

endmodule

// File: tb/tb_axi_rd_req_gen.sv
// Randomized bench for axi_rd_req_gen: a queue-based burst model derived from
// the splitting rules, plus a read-master model that returns beats with gaps.
module tb_axi_rd_req_gen;

    localparam int AW = 16, LW = 20, STRB = 4, MAXB = 1024, TO = 1024;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid, cmd_ready, req, data_valid, busy, done, err;
    logic [AW-1:0] cmd_addr, addr;
    logic [LW-1:0] cmd_len, burst_len;
    logic [15:0]   burst_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    int unsigned q_a[$];
    int unsigned q_l[$];

    axi_rd_req_gen #(
        .AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(AW), .LEN_WIDTH(LW),
        .MAX_BURST_BYTES(MAXB), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .req(req), .addr(addr),
        .burst_len(burst_len), .data_valid(data_valid), .busy(busy), .done(done),
        .err(err), .burst_cnt(burst_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Expected burst list: greedy split by remaining bytes, cap and 4 KB edge.
    task automatic build(input int unsigned a, input int unsigned len);
        int unsigned cur, rem, b;
        q_a.delete(); q_l.delete();
        cur = a % 65536; rem = len;
        while (rem > 0) begin
            b = rem;
            if (b > MAXB) b = MAXB;
            if (b > 4096 - (cur % 4096)) b = 4096 - (cur % 4096);
            q_a.push_back(cur); q_l.push_back(b);
            cur = (cur + b) % 65536;
            rem = rem - b;
        end
    endtask

    task automatic wait_ready();
        int i;
        i = 0;
        while (cmd_ready !== 1'b1 && i < 3000) begin
            @(negedge clk); i++;
        end
        if (cmd_ready !== 1'b1) begin
            check("ready_timeout", 32'(cmd_ready), 32'd1);
            rst_n = 1'b0; @(negedge clk); rst_n = 1'b1; @(negedge clk);
        end
    endtask

    task automatic run_cmd(input int unsigned a, input int unsigned len, input int stall_after);
        bit bad, seen_req;
        int got, beats, k;
        wait_ready();
        bad = ((a % STRB) != 0) || ((len % STRB) != 0);
        if (bad) begin q_a.delete(); q_l.delete(); end
        else build(a, len);
        // cycle N: command presented; a stray beat strobe here must be ignored
        cmd_addr = AW'(a); cmd_len = LW'(len); cmd_valid = 1'b1;
        data_valid = 1'($urandom_range(0, 1));
        @(negedge clk);
        cmd_valid = 1'b0; data_valid = 1'b0;
        if (q_a.size() == 0) begin
            check("nob_done", 32'(done), 32'd1);
            check("nob_req", 32'(req), 32'd0);
            check("nob_err", 32'(err), 32'(bad));
            check("nob_bcnt", 32'(burst_cnt), 32'd0);
            @(negedge clk);
            check("nob_done_pulse", 32'(done), 32'd0);
            check("nob_req2", 32'(req), 32'd0);
            check("nob_ready", 32'(cmd_ready), 32'd1);
            return;
        end
        check("calc_busy", 32'(busy), 32'd1);
        check("calc_req", 32'(req), 32'd0);
        data_valid = 1'($urandom_range(0, 1));   // CALC: ignored
        for (int bi = 0; bi < q_a.size(); bi++) begin
            @(negedge clk);
            check("req", 32'(req), 32'd1);
            check("req_addr", 32'(addr), q_a[bi]);
            check("req_blen", 32'(burst_len), q_l[bi]);
            data_valid = 1'($urandom_range(0, 1));   // ISSUE: ignored
            beats = int'(q_l[bi] / STRB);
            got = 0;
            while (got < beats) begin
                @(negedge clk);
                check("wait_req", 32'(req), 32'd0);
                check("hold_addr", 32'(addr), q_a[bi]);
                check("hold_blen", 32'(burst_len), q_l[bi]);
                if (stall_after >= 0 && bi == 0 && got == stall_after) begin
                    data_valid = 1'b0; seen_req = 1'b0; k = 1;
                    while (done !== 1'b1 && k < 1100) begin
                        if (req === 1'b1) seen_req = 1'b1;
                        @(negedge clk); k++;
                    end
                    check("wdog_done_cycle", 32'(k), 32'd1024);
                    check("wdog_err", 32'(err), 32'd1);
                    check("wdog_no_req", 32'(seen_req), 32'd0);
                    check("wdog_bcnt", 32'(burst_cnt), 32'd1);
                    @(negedge clk);
                    check("wdog_ready", 32'(cmd_ready), 32'd1);
                    check("wdog_req", 32'(req), 32'd0);
                    return;
                end
                if ($urandom_range(0, 2) == 0) data_valid = 1'b0;
                else begin data_valid = 1'b1; got++; end
            end
            @(negedge clk);   // cycle after the final beat
            data_valid = 1'b0;
            if (bi == q_a.size() - 1) begin
                check("done", 32'(done), 32'd1);
                check("done_err", 32'(err), 32'd0);
                check("done_bcnt", 32'(burst_cnt), 32'(q_a.size()));
                check("done_req", 32'(req), 32'd0);
                @(negedge clk);
                check("done_pulse", 32'(done), 32'd0);
                check("idle_busy", 32'(busy), 32'd0);
                check("idle_ready", 32'(cmd_ready), 32'd1);
            end else begin
                check("gap_req", 32'(req), 32'd0);
                check("gap_done", 32'(done), 32'd0);
                data_valid = 1'($urandom_range(0, 1));   // CALC: ignored
            end
        end
    endtask

    initial begin
        int unsigned ra, rl;
        rst_n = 1'b0; cmd_valid = 1'b0; data_valid = 1'b0;
        cmd_addr = '0; cmd_len = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_req", 32'(req), 32'd0);
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_blen", 32'(burst_len), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_bcnt", 32'(burst_cnt), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_cmd(32'h0000, 32'd64, -1);
        run_cmd(32'h0F00, 32'h300, -1);
        run_cmd(32'h0000, 32'd3000, -1);
        run_cmd(32'h0000, 32'd0, -1);
        run_cmd(32'h0002, 32'd16, -1);
        run_cmd(32'h0000, 32'd64, 3);
        run_cmd(32'hFFF0, 32'd64, -1);

        // Reset mid-WAIT: everything drops immediately, then a clean restart.
        wait_ready();
        cmd_addr = 16'h0100; cmd_len = 20'd256; cmd_valid = 1'b1;
        @(negedge clk); cmd_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_req", 32'(req), 32'd1);
        @(negedge clk); data_valid = 1'b1;
        @(negedge clk); data_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("arst_req", 32'(req), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_ready", 32'(cmd_ready), 32'd1);
        check("arst_bcnt", 32'(burst_cnt), 32'd0);
        check("arst_addr", 32'(addr), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_req", 32'(req), 32'd0);
        end
        run_cmd(32'h0100, 32'd128, -1);

        for (int i = 0; i < 12; i++) begin
            ra = $urandom_range(0, 16383) * 4;
            rl = $urandom_range(0, 512) * 4;
            if ($urandom_range(0, 7) == 0) ra = ra | 32'd1;
            if ($urandom_range(0, 7) == 0) rl = rl + 32'd2;
            run_cmd(ra, rl, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
